// File: rtl/sa_feeder.sv
// rtl/sa_feeder.sv - batches vertices, then streams matrix rows and vertex
// components into the systolic array edges with per-lane skew and tags.
module sa_feeder #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mat_we_i,
    input  logic [$clog2(N)-1:0]  mat_addr_i,
    input  logic [N*WIDTH-1:0]    mat_row_i,
    output logic                  mat_ready_o,
    input  logic                  vtx_valid_i,
    output logic                  vtx_ready_o,
    input  logic [N*WIDTH-1:0]    vtx_i,
    input  logic                  flush_i,
    output logic [N*WIDTH-1:0]    a_edge_o,
    output logic [N*WIDTH-1:0]    b_edge_o,
    output logic [N*8-1:0]        t_edge_o,
    output logic                  pass_done_o,
    output logic [$clog2(N):0]    vtx_cnt_o
);
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(N) + 1;
    localparam int BW = $clog2(N + 1);

    localparam logic [7:0] TAG_IDLE = 8'hFF;
    localparam logic [7:0] TAG_CLR  = 8'h04;
    localparam logic [7:0] TAG_DATA = 8'h01;
    localparam logic [7:0] TAG_LAST = 8'h03;

    typedef enum logic [1:0] {FILL, STREAM, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [CW-1:0]   buf_cnt, buf_d;
    logic [CW-1:0]   vcnt_q, vcnt_d;
    logic            hs, mat_wr;

    logic [WIDTH-1:0] mat_q [N][N];
    logic [WIDTH-1:0] vtx_q [N][N];

    assign vtx_ready_o = (state_q == FILL) && (buf_cnt < CW'(N));
    assign mat_ready_o = (state_q == FILL) && (buf_cnt == '0);
    assign hs          = vtx_valid_i & vtx_ready_o;
    assign mat_wr      = mat_we_i & mat_ready_o;
    assign vtx_cnt_o   = vcnt_q;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        buf_d       = buf_cnt;
        vcnt_d      = vcnt_q;
        pass_done_o = 1'b0;
        case (state_q)
            FILL: begin
                buf_d  = buf_cnt + CW'(hs);
                beat_d = '0;
                if (buf_d == CW'(N) || (flush_i && buf_d != '0)) begin
                    state_d = STREAM;
                    vcnt_d  = buf_d;
                end
            end
            STREAM: begin
                if (beat_q == BW'(N)) begin
                    state_d = DRAIN;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            DRAIN: begin
                // Lane N-1 shows LAST on the final drain cycle.
                if (beat_q == BW'(N - 1)) begin
                    pass_done_o = 1'b1;
                    state_d     = FILL;
                    buf_d       = '0;
                    beat_d      = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            beat_q  <= '0;
            buf_cnt <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            buf_cnt <= buf_d;
            vcnt_q  <= vcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mat_q[r][c] <= '0;
                    vtx_q[r][c] <= '0;
                end
            end
        end else begin
            if (mat_wr) begin
                for (int c = 0; c < N; c++) mat_q[mat_addr_i][c] <= mat_row_i[c*WIDTH +: WIDTH];
            end
            if (hs) begin
                for (int c = 0; c < N; c++) vtx_q[buf_cnt[AW-1:0]][c] <= vtx_i[c*WIDTH +: WIDTH];
            end
        end
    end

    logic [WIDTH-1:0] a_nxt [N];
    logic [WIDTH-1:0] b_nxt [N];
    logic [7:0]       t_nxt [N];
    logic [AW-1:0]    k;

    always_comb begin
        k = AW'(beat_q - BW'(1));
        for (int i = 0; i < N; i++) begin
            a_nxt[i] = '0;
            b_nxt[i] = '0;
            t_nxt[i] = TAG_IDLE;
            if (state_q == STREAM) begin
                if (beat_q == '0) begin
                    t_nxt[i] = TAG_CLR;
                end else begin
                    a_nxt[i] = mat_q[i][k];
                    t_nxt[i] = (beat_q == BW'(N)) ? TAG_LAST : TAG_DATA;
                    // Empty batch slots feed zeros so their PEs stay at 0.
                    b_nxt[i] = (CW'(i) < vcnt_q) ? vtx_q[i][k] : '0;
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WIDTH-1:0] a_sr [i+1];
        logic [WIDTH-1:0] b_sr [i+1];
        logic [7:0]       t_sr [i+1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int d = 0; d <= i; d++) begin
                    a_sr[d] <= '0;
                    b_sr[d] <= '0;
                    t_sr[d] <= TAG_IDLE;
                end
            end else begin
                a_sr[0] <= a_nxt[i];
                b_sr[0] <= b_nxt[i];
                t_sr[0] <= t_nxt[i];
                for (int d = 1; d <= i; d++) begin
                    a_sr[d] <= a_sr[d-1];
                    b_sr[d] <= b_sr[d-1];
                    t_sr[d] <= t_sr[d-1];
                end
            end
        end

        assign a_edge_o[i*WIDTH +: WIDTH] = a_sr[i];
        assign b_edge_o[i*WIDTH +: WIDTH] = b_sr[i];
        assign t_edge_o[i*8 +: 8]         = t_sr[i];
    end
endmodule

// File: doc/sa_feeder.md
Name: sa_feeder

Overview:
- Upstream stage of the vertex-transform systolic array: buffers a batch of up to N vertices, then streams the stored NxN matrix and the vertex components into the array edges with per-lane skew.
- Each pass is framed with tags: a clear beat, then N data beats, the last one marked.
- Row lane i carries M[i][k] plus its tag into the row-i edge PE; column lane j carries V[j][k] into the column-j edge PE.
- PE(i,j) accumulates sum_k M[i][k]*V[j][k].

Parameters:
- WIDTH, 32, signed operand width.
- N, 4, array dimension: rows, columns, vertex components, batch size.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mat_we_i  in  1  matrix row write strobe.
- mat_addr_i  in  $clog2(N)  matrix row index.
- mat_row_i  in  N*WIDTH  row data; component k at bits [k*WIDTH +: WIDTH].
- mat_ready_o  out  1  matrix writes accepted (FILL state and buf_cnt==0).
- vtx_valid_i  in  1  vertex valid.
- vtx_ready_o  out  1  vertex accepted when valid&ready.
- vtx_i  in  N*WIDTH  vertex components, same packing as mat_row_i.
- flush_i  in  1  stream the partial batch now.
- a_edge_o  out  N*WIDTH  row-lane operands.
- b_edge_o  out  N*WIDTH  column-lane operands.
- t_edge_o  out  N*8  row-lane tags.
- pass_done_o  out  1  one-cycle pulse when the last skewed beat is on the edges.
- vtx_cnt_o  out  $clog2(N)+1  valid vertices in the current or last pass.

Behaviour:
- Tags:
  - IDLE = 8'hFF.
  - CLR = 8'h04 (bit2 zeroes the PE accumulators).
  - DATA = 8'h01.
  - LAST = 8'h03.
  - Bit2 is clear on DATA and LAST.
- Reset:
  - All a/b edges 0; all tag lanes 8'hFF.
  - pass_done_o 0, vtx_cnt_o 0, buf_cnt 0.
  - Matrix and vertex buffers zeroed.
  - State FILL.
  - Reset mid-pass aborts immediately; the next cycle drives idle edges.
- FILL state:
  - vtx_ready_o = (buf_cnt < N).
  - Handshake stores vtx_i in slot buf_cnt; buf_cnt increments.
  - mat_we_i with mat_ready_o writes row mat_addr_i. Writes are ignored in any other state or when buf_cnt != 0.
  - Go to STREAM the cycle after buf_cnt reaches N, or after flush_i is seen with buf_cnt>0 (counting a same-cycle handshake).
  - flush_i with buf_cnt==0 and no handshake is ignored.
  - vtx_cnt_o latches buf_cnt on entry to STREAM.
- STREAM state:
  - Lasts N+1 cycles (internal beat b=0..N). S = first STREAM cycle.
  - Beat 0: operands 0, tag CLR.
  - Beat 1+k: row operand M[i][k] with tag DATA, or LAST when k=N-1. Column operand V[j][k].
  - Slots j >= vtx_cnt_o drive 0 on their column operands.
- Skew and timing:
  - Registered output, then per-lane delay lines: row lane i delayed i cycles, column lane j delayed j cycles.
  - Lane i shows beat b in cycle S+1+b+i.
  - Lanes with no beat in flight drive operand 0 and tag IDLE.
- DRAIN state:
  - Waits until cycle S+2N, when lane N-1 shows LAST; pass_done_o pulses in that cycle.
  - Next cycle: FILL with buf_cnt=0.
  - vtx_ready_o is 0 throughout STREAM and DRAIN.
- Arithmetic: no arithmetic; operands pass through bit-exact, signed.
- Back-to-back passes: the next pass's CLR on lane 0 is no earlier than S+2N+2, so there is no tag overlap on any lane.

Test Plan:
- Reset with clk running -> all t_edge lanes 8'hFF, a/b edges 0, vtx_ready_o=1, mat_ready_o=1, pass_done_o=0.
- Load M=identity; send 4 vertices V[j]=(j+1,2,3,4); valid held high -> ready drops after 4th handshake. Lane 0 tag sequence: 04,01,01,01,03 in cycles S+1..S+5. Lane 3 the same, shifted +3. b lane 1 emits 2,2,3,4 in cycles S+3..S+6. pass_done_o pulses in cycle S+8.
- Two vertices then flush_i -> vtx_cnt_o=2; b lanes 2,3 stay 0 across the whole pass; row lanes carry full M rows.
- flush_i with buf_cnt=0 -> no state change, tags stay 8'hFF. flush_i in the same cycle as the 1st handshake -> pass with vtx_cnt_o=1.
- mat_we_i during STREAM with row 0 = all 7s -> ignored; the next pass still emits the previous M[0][k].
- reset asserted at S+3 -> next cycle all tags 8'hFF, buf_cnt=0, no pass_done_o. Operands -5 and 32'h7FFFFFFF pass through bit-exact.
